arb2_burst: RTL and testbench
=============================

# arb2_burst

Two-requester round-robin burst arbiter that shares one WIDTH-bit output channel between requester A and requester B. It owns the select line of the word-wide 2:1 multiplexer in front of the shared channel. A burst runs until the owner marks its last beat, drops its request, or reaches MAX_BURST beats; ownership then alternates fairly. It sits between the two producer blocks and the single downstream consumer.

## Interface
- WIDTH, 8, data word width (>= 1)
- MAX_BURST, 4, maximum beats per ownership (>= 2)

- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- req_a  input  1  requester A has a valid word
- data_a  input  WIDTH  requester A word
- last_a  input  1  current A word is the final beat of its burst
- req_b  input  1  requester B has a valid word
- data_b  input  WIDTH  requester B word
- last_b  input  1  current B word is the final beat of its burst
- out_ready  input  1  consumer accepts the word this cycle
- out_valid  output  1  channel carries a valid word
- out_data  output  WIDTH  muxed word, 0 when no owner
- grant_a  output  1  A owns the channel; A's word is consumed when grant_a & out_ready
- grant_b  output  1  B owns the channel
- owner  output  2  state code: 00 IDLE, 01 OWN_A, 10 OWN_B

## Operation
- States: IDLE, OWN_A, OWN_B. Code 11 is illegal and returns to IDLE on the next edge.
- Internal registers:
  - state
  - prio: 0 favours A, 1 favours B
  - beat_cnt: $clog2(MAX_BURST) bits
- IDLE transitions:
  - only req_a -> OWN_A
  - only req_b -> OWN_B
  - both -> OWN_A if prio=0, else OWN_B
  - none -> stay
  - beat_cnt cleared.
- OWN_X outputs:
  - grant_X=1
  - out_valid=req_X
  - out_data=data_X through the mux sub-module, select = (state==OWN_B)
- Beat: a beat occurs when req_X & out_ready in OWN_X.
- Release: OWN_X -> IDLE on the clock edge ending a cycle in which any of these holds:
  - a beat with last_X=1
  - a beat with beat_cnt==MAX_BURST-1
  - req_X=0, meaning an abandoned burst; no beat occurs
- On release, prio <= 1 if X=A, 0 if X=B, and beat_cnt <= 0.
- Otherwise a beat increments beat_cnt. Without a beat, beat_cnt holds.
- A beat is counted only while out_ready=1. A stalled owner keeps ownership indefinitely while req_X stays high.
- The non-owner's req, data and last are ignored. Its request stays pending and does not affect the owner.
- Reset (asynchronous, any cycle including mid-burst):
  - state=IDLE, prio=0, beat_cnt=0
  - all outputs 0 immediately
  - the interrupted burst is dropped, not resumed

## Timing
- Outputs are combinational from state and the owner's inputs; no registered data path, so data has zero latency once owned.
- Grant latency: a request seen in IDLE in cycle n gives grant in cycle n+1. The first beat can complete in cycle n+1.
- There is always exactly one IDLE cycle between consecutive ownerships, so A then B back-to-back yields a one-cycle bubble.
- Maximum burst: MAX_BURST beats, then forced release even if last_X=0. The remainder of the burst re-arbitrates.
- Simultaneous last_X and beat_cnt==MAX_BURST-1 gives a single release, identical to either condition alone.
- Under continuous contention with full bursts, each requester receives MAX_BURST beats per 2*(MAX_BURST+1) cycles.

## Structure
- Shared package (guia_pkg):
  - state codes ST_IDLE=2'b00, ST_OWN_A=2'b01, ST_OWN_B=2'b10
  - default WIDTH and MAX_BURST constants
- Sub-module mux_word: WIDTH-bit 2:1 multiplexer built from not/and/or gates per bit (output s, inputs a, b, select). Instantiated once; the arbiter gates its output to 0 in IDLE.
- The arbiter is a single always block for state, prio and beat_cnt, plus continuous assigns for the outputs.

## Test plan
- Reset: hold reset=1 mid-burst (state OWN_A, beat_cnt=2) -> owner=00, grant_a=grant_b=0, out_valid=0, out_data=0 immediately; after release with no requests, owner stays 00.
- Single requester: req_a=1, data_a=8'hA5, out_ready=1, last_a on beat 3 -> grant_a from cycle n+1, three beats of 8'hA5, IDLE on the following edge, prio=1.
- Contention fairness: req_a=req_b=1 continuously, last never asserted, MAX_BURST=4 -> alternating 4-beat bursts A,B,A,B with a one-cycle IDLE between; A wins first after reset.
- Stall: in OWN_B, out_ready=0 for 5 cycles, then 1 -> grant_b held, beat_cnt unchanged during the stall, counting resumes afterwards; A's pending request is not granted until B releases.
- Abandon: in OWN_A after 1 beat, drop req_a with last_a=0 -> IDLE next edge, prio=1; a pending req_b gets the grant one cycle later.
- Data steering: data_a=8'h3C, data_b=8'hC3 both requesting -> out_data=8'h3C only in OWN_A, 8'hC3 only in OWN_B, 8'h00 in IDLE.

Source files
------------

// File: rtl/guia_pkg.sv
// Shared definitions for the two-requester burst arbiter.
// Provides the ownership state encoding (also driven out on the owner port)
// and the default word width / maximum burst length.
package guia_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_OWN_A = 2'b01,
    ST_OWN_B = 2'b10
  } state_e;

  localparam int unsigned DEF_WIDTH     = 8;
  localparam int unsigned DEF_MAX_BURST = 4;

endpackage

// File: rtl/mux_word.sv
// WIDTH-bit 2:1 word multiplexer built from gate primitives per bit.
// Ports:
//   s      - selected word (a when select=0, b when select=1)
//   a, b   - candidate words
//   select - 0 picks a, 1 picks b
module mux_word #(
  parameter int unsigned WIDTH = 8
) (
  output logic [WIDTH-1:0] s,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             select
);

  logic sel_n;

  not u_inv (sel_n, select);

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    logic a_term;
    logic b_term;
    and u_and_a (a_term, a[i], sel_n);
    and u_and_b (b_term, b[i], select);
    or  u_or    (s[i], a_term, b_term);
  end

endmodule

// File: rtl/arb2_burst.sv
// Two-requester round-robin burst arbiter driving the select of a shared
// WIDTH-bit 2:1 channel mux. An owner keeps the channel until it delivers a
// beat marked last, delivers MAX_BURST beats, or drops its request; each
// release is followed by one IDLE cycle and priority flips to the other side.
// Ports:
//   clk, reset             - rising-edge clock, async active-high reset
//   req_a, data_a, last_a  - requester A valid / word / final-beat flag
//   req_b, data_b, last_b  - requester B valid / word / final-beat flag
//   out_ready              - consumer accepts the word this cycle
//   out_valid, out_data    - shared channel (data forced to 0 with no owner)
//   grant_a, grant_b       - ownership indications
//   owner                  - state code: 00 IDLE, 01 OWN_A, 10 OWN_B
module arb2_burst
  import guia_pkg::*;
#(
  parameter int unsigned WIDTH     = DEF_WIDTH,
  parameter int unsigned MAX_BURST = DEF_MAX_BURST
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_a,
  input  logic [WIDTH-1:0] data_a,
  input  logic             last_a,
  input  logic             req_b,
  input  logic [WIDTH-1:0] data_b,
  input  logic             last_b,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic             grant_a,
  output logic             grant_b,
  output logic [1:0]       owner
);

  localparam int unsigned          CNT_W    = $clog2(MAX_BURST);
  localparam logic [CNT_W-1:0]     CNT_LAST = CNT_W'(MAX_BURST - 1);

  state_e           state_q;
  logic             prio_q;      // 0 favours A, 1 favours B
  logic [CNT_W-1:0] beat_cnt_q;

  logic             own_a;
  logic             own_b;
  logic             req_own;
  logic             last_own;
  logic             beat;
  logic             release_burst;
  logic [WIDTH-1:0] mux_s;

  assign own_a    = (state_q == ST_OWN_A);
  assign own_b    = (state_q == ST_OWN_B);

  // Only the current owner's request/last are visible; the other side waits.
  assign req_own  = (own_a & req_a)  | (own_b & req_b);
  assign last_own = (own_a & last_a) | (own_b & last_b);
  assign beat     = req_own & out_ready;

  // A dropped request ends the burst with no beat; otherwise a beat ends it
  // when flagged last or when it is the MAX_BURST-th beat.
  assign release_burst = (own_a | own_b) &
                         (~req_own | (beat & (last_own | (beat_cnt_q == CNT_LAST))));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      prio_q     <= 1'b0;
      beat_cnt_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          beat_cnt_q <= '0;
          if (req_a && (!req_b || !prio_q)) begin
            state_q <= ST_OWN_A;
          end else if (req_b) begin
            state_q <= ST_OWN_B;
          end
        end
        ST_OWN_A, ST_OWN_B: begin
          if (release_burst) begin
            state_q    <= ST_IDLE;
            prio_q     <= own_a;
            beat_cnt_q <= '0;
          end else if (beat) begin
            beat_cnt_q <= beat_cnt_q + CNT_W'(1);
          end
        end
        default: begin
          state_q    <= ST_IDLE;
          beat_cnt_q <= '0;
        end
      endcase
    end
  end

  mux_word #(
    .WIDTH (WIDTH)
  ) u_mux (
    .s      (mux_s),
    .a      (data_a),
    .b      (data_b),
    .select (own_b)
  );

  assign grant_a   = own_a;
  assign grant_b   = own_b;
  assign out_valid = req_own;
  assign out_data  = mux_s & {WIDTH{own_a | own_b}};
  assign owner     = state_q;

endmodule

// File: tb/tb_arb2_burst.sv
module tb_arb2_burst;

  localparam int unsigned WIDTH     = 8;
  localparam int unsigned MAX_BURST = 4;

  logic             clk = 1'b0;
  logic             reset;
  logic             req_a, last_a, req_b, last_b, out_ready;
  logic [WIDTH-1:0] data_a, data_b;
  logic             out_valid, grant_a, grant_b;
  logic [WIDTH-1:0] out_data;
  logic [1:0]       owner;

  int checks = 0;
  int errors = 0;

  arb2_burst #(
    .WIDTH     (WIDTH),
    .MAX_BURST (MAX_BURST)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .req_a     (req_a),
    .data_a    (data_a),
    .last_a    (last_a),
    .req_b     (req_b),
    .data_b    (data_b),
    .last_b    (last_b),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .grant_a   (grant_a),
    .grant_b   (grant_b),
    .owner     (owner)
  );

  always #5 clk = ~clk;

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    req_a = 1'b0; last_a = 1'b0; data_a = '0;
    req_b = 1'b0; last_b = 1'b0; data_b = '0;
    out_ready = 1'b0;
  endtask

  // Leaves the bench just after a rising edge with the DUT in IDLE, prio=0.
  task automatic do_reset();
    clear_inputs();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    clear_inputs();
    reset = 1'b0;
    req_a = 1'b1; data_a = 8'h77; out_ready = 1'b1;
    reset = 1'b1;
    step();
    reset = 1'b0;
    // Build up OWN_A with beat_cnt=2: cycle0 IDLE, cycles 1,2 beats.
    step(); step(); step();
    #1;
    checks++;
    if (owner !== 2'b01) begin errors++; $display("FAIL reset_pre_owner: got %b expected %b", owner, 2'b01); end
    reset = 1'b1;
    #1;
    checks++;
    if (owner !== 2'b00) begin errors++; $display("FAIL reset_async_owner: got %b expected %b", owner, 2'b00); end
    checks++;
    if ({grant_a, grant_b, out_valid} !== 3'b000) begin errors++; $display("FAIL reset_async_flags: got %b expected %b", {grant_a, grant_b, out_valid}, 3'b000); end
    checks++;
    if (out_data !== 8'h00) begin errors++; $display("FAIL reset_async_data: got %h expected %h", out_data, 8'h00); end
    step();
    clear_inputs();
    reset = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1;
      checks++;
      if (owner !== 2'b00 || grant_a !== 1'b0) begin errors++; $display("FAIL reset_after_idle: got owner %b grant_a %b expected 00 0", owner, grant_a); end
      step();
    end
  endtask

  task automatic test_single();
    do_reset();
    req_a = 1'b1; data_a = 8'hA5; out_ready = 1'b1; last_a = 1'b0;
    #1;
    checks++;
    if (owner !== 2'b00 || grant_a !== 1'b0) begin errors++; $display("FAIL single_req_cycle: got owner %b grant_a %b expected 00 0", owner, grant_a); end
    for (int beat = 1; beat <= 3; beat++) begin
      step();
      last_a = (beat == 3);
      #1;
      checks++;
      if (owner !== 2'b01 || grant_a !== 1'b1 || grant_b !== 1'b0) begin errors++; $display("FAIL single_grant_beat%0d: got owner %b ga %b gb %b expected 01 1 0", beat, owner, grant_a, grant_b); end
      checks++;
      if (out_valid !== 1'b1 || out_data !== 8'hA5) begin errors++; $display("FAIL single_data_beat%0d: got v %b d %h expected 1 a5", beat, out_valid, out_data); end
    end
    step();
    last_a = 1'b0;
    req_b = 1'b1;
    #1;
    checks++;
    if (owner !== 2'b00 || out_data !== 8'h00) begin errors++; $display("FAIL single_release_idle: got owner %b data %h expected 00 00", owner, out_data); end
    step();
    // prio=1 after A's release, so B wins the contended IDLE cycle.
    #1;
    checks++;
    if (owner !== 2'b10 || grant_b !== 1'b1) begin errors++; $display("FAIL single_prio_flip: got owner %b gb %b expected 10 1", owner, grant_b); end
  endtask

  task automatic test_fairness();
    int beats_a;
    int beats_b;
    beats_a = 0; beats_b = 0;
    do_reset();
    req_a = 1'b1; req_b = 1'b1; data_a = 8'h3C; data_b = 8'hC3; out_ready = 1'b1;
    for (int c = 0; c < 20; c++) begin
      int         ph;
      logic [1:0] eo;
      logic [7:0] ed;
      ph = c % 10;
      eo = (ph == 0 || ph == 5) ? 2'b00 : ((ph < 5) ? 2'b01 : 2'b10);
      ed = (eo == 2'b01) ? 8'h3C : ((eo == 2'b10) ? 8'hC3 : 8'h00);
      #1;
      checks++;
      if (owner !== eo) begin errors++; $display("FAIL fair_owner_c%0d: got %b expected %b", c, owner, eo); end
      checks++;
      if (out_data !== ed) begin errors++; $display("FAIL fair_data_c%0d: got %h expected %h", c, out_data, ed); end
      checks++;
      if (out_valid !== (eo != 2'b00) || grant_a !== (eo == 2'b01) || grant_b !== (eo == 2'b10)) begin
        errors++; $display("FAIL fair_flags_c%0d: got v %b ga %b gb %b for owner %b", c, out_valid, grant_a, grant_b, eo);
      end
      if (out_valid && grant_a) beats_a++;
      if (out_valid && grant_b) beats_b++;
      step();
    end
    checks++;
    if (beats_a !== 8 || beats_b !== 8) begin errors++; $display("FAIL fair_beat_share: got a %0d b %0d expected 8 8", beats_a, beats_b); end
  endtask

  task automatic test_stall();
    do_reset();
    req_b = 1'b1; data_b = 8'h5A; out_ready = 1'b1;
    for (int c = 0; c < 12; c++) begin
      logic [1:0] eo;
      req_a     = (c >= 2);
      data_a    = 8'h11;
      out_ready = !(c >= 2 && c <= 6);
      eo = (c == 0 || c == 10) ? 2'b00 : ((c == 11) ? 2'b01 : 2'b10);
      #1;
      checks++;
      if (owner !== eo) begin errors++; $display("FAIL stall_owner_c%0d: got %b expected %b", c, owner, eo); end
      if (eo == 2'b10) begin
        checks++;
        if (out_valid !== 1'b1 || out_data !== 8'h5A || grant_a !== 1'b0) begin
          errors++; $display("FAIL stall_hold_c%0d: got v %b d %h ga %b expected 1 5a 0", c, out_valid, out_data, grant_a);
        end
      end
      step();
    end
  endtask

  task automatic test_abandon();
    do_reset();
    req_a = 1'b1; data_a = 8'h11; data_b = 8'h22; out_ready = 1'b1;
    req_b = 1'b1;
    #1;
    checks++;
    if (owner !== 2'b00) begin errors++; $display("FAIL abandon_idle0: got %b expected 00", owner); end
    step();
    #1;
    checks++;
    if (owner !== 2'b01 || out_data !== 8'h11) begin errors++; $display("FAIL abandon_beat1: got owner %b d %h expected 01 11", owner, out_data); end
    step();
    req_a = 1'b0; last_a = 1'b0;
    #1;
    checks++;
    if (owner !== 2'b01 || out_valid !== 1'b0 || out_data !== 8'h11) begin
      errors++; $display("FAIL abandon_drop: got owner %b v %b d %h expected 01 0 11", owner, out_valid, out_data);
    end
    step();
    req_a = 1'b1;
    #1;
    checks++;
    if (owner !== 2'b00) begin errors++; $display("FAIL abandon_idle: got %b expected 00", owner); end
    step();
    #1;
    checks++;
    if (owner !== 2'b10 || out_data !== 8'h22 || out_valid !== 1'b1) begin
      errors++; $display("FAIL abandon_b_grant: got owner %b d %h v %b expected 10 22 1", owner, out_data, out_valid);
    end
  endtask

  task automatic test_last_at_max();
    do_reset();
    req_a = 1'b1; data_a = 8'h0F; out_ready = 1'b1;
    req_b = 1'b1; last_b = 1'b1; data_b = 8'hF0;
    for (int c = 0; c < 7; c++) begin
      logic [1:0] eo;
      last_a = (c == 4);
      eo = (c == 0 || c == 5) ? 2'b00 : ((c == 6) ? 2'b10 : 2'b01);
      #1;
      checks++;
      if (owner !== eo) begin errors++; $display("FAIL lastmax_owner_c%0d: got %b expected %b", c, owner, eo); end
      step();
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_fairness();
    test_stall();
    test_abandon();
    test_last_at_max();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
